// File: rtl/tlb_lookup_ctrl.sv
// TLB lookup control: accepts a translation request, compares tags, and on a miss walks and refills the victim way.
// Latency: a hit response is valid two cycles after accept; a miss adds the walk time plus the refill cycle.
// Backpressure: one request in flight; req_ready only in IDLE, resp_valid and ptw_req_valid hold until accepted.
module tlb_lookup_ctrl #(
  parameter int NUM_WAYS       = 4,
  parameter int SET_INDEX_BITS = 4,
  parameter int LRU_BITS       = 4,
  parameter int CNT_BITS       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   req_vaddr,
  input  logic                          req_is_write,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [31:0]                   resp_paddr,
  output logic                          resp_hit,
  output logic                          resp_fault,
  output logic [SET_INDEX_BITS-1:0]     rd_set_index,
  input  logic [NUM_WAYS-1:0]           rd_valid,
  input  logic [NUM_WAYS*20-1:0]        rd_vpn,
  input  logic [NUM_WAYS*20-1:0]        rd_ppn,
  input  logic [NUM_WAYS*2-1:0]         rd_perms,
  input  logic [NUM_WAYS*LRU_BITS-1:0]  rd_lru_count,
  output logic                          wr_en,
  output logic [SET_INDEX_BITS-1:0]     wr_set_index,
  output logic [1:0]                    wr_way,
  output logic                          wr_valid,
  output logic [19:0]                   wr_vpn,
  output logic [19:0]                   wr_ppn,
  output logic [1:0]                    wr_perms,
  output logic [LRU_BITS-1:0]           wr_lru_count,
  output logic                          lru_update_en,
  output logic [SET_INDEX_BITS-1:0]     lru_set_index,
  output logic [1:0]                    lru_way,
  output logic                          ptw_req_valid,
  input  logic                          ptw_req_ready,
  output logic [19:0]                   ptw_req_vpn,
  input  logic                          ptw_resp_valid,
  input  logic [19:0]                   ptw_resp_ppn,
  input  logic [1:0]                    ptw_resp_perms,
  input  logic                          ptw_resp_fault,
  output logic [CNT_BITS-1:0]           hit_count,
  output logic [CNT_BITS-1:0]           miss_count
);

  typedef enum logic [2:0] {IDLE, LOOKUP, PTW_REQ, PTW_WAIT, REFILL, RESP} state_t;

  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  state_t                      state_q, state_d;
  logic [31:0]                 vaddr_q, vaddr_d;
  logic                        is_write_q, is_write_d;
  logic [19:0]                 walk_ppn_q, walk_ppn_d;
  logic [1:0]                  walk_perms_q, walk_perms_d;
  logic                        req_ready_q, req_ready_d;
  logic                        resp_valid_q, resp_valid_d;
  logic [31:0]                 resp_paddr_q, resp_paddr_d;
  logic                        resp_hit_q, resp_hit_d;
  logic                        resp_fault_q, resp_fault_d;
  logic                        wr_en_q, wr_en_d;
  logic [SET_INDEX_BITS-1:0]   wr_set_index_q, wr_set_index_d;
  logic [1:0]                  wr_way_q, wr_way_d;
  logic                        wr_valid_q, wr_valid_d;
  logic [19:0]                 wr_vpn_q, wr_vpn_d;
  logic [19:0]                 wr_ppn_q, wr_ppn_d;
  logic [1:0]                  wr_perms_q, wr_perms_d;
  logic [LRU_BITS-1:0]         wr_lru_count_q, wr_lru_count_d;
  logic                        lru_update_en_q, lru_update_en_d;
  logic [SET_INDEX_BITS-1:0]   lru_set_index_q, lru_set_index_d;
  logic [1:0]                  lru_way_q, lru_way_d;
  logic                        ptw_req_valid_q, ptw_req_valid_d;
  logic [19:0]                 ptw_req_vpn_q, ptw_req_vpn_d;
  logic [CNT_BITS-1:0]         hit_count_q, hit_count_d;
  logic [CNT_BITS-1:0]         miss_count_q, miss_count_d;

  logic [19:0]                 vpn;
  logic [SET_INDEX_BITS-1:0]   set_idx;
  logic                        hit;
  logic [1:0]                  hit_way;
  logic [19:0]                 hit_ppn;
  logic [1:0]                  hit_perms;
  logic                        inv_found;
  logic [1:0]                  inv_way;
  logic [1:0]                  min_way;
  logic [LRU_BITS-1:0]         min_lru;
  logic [1:0]                  victim_way;
  logic                        fault_now;

  function automatic logic perm_ok(input logic [1:0] perms, input logic is_wr);
    return is_wr ? perms[1] : perms[0];
  endfunction

  assign vpn          = vaddr_q[31:12];
  assign set_idx      = vaddr_q[12 +: SET_INDEX_BITS];
  assign rd_set_index = (state_q == IDLE) ? '0 : set_idx;

  // Tag compare across the set; scanning downwards lets the lowest matching way win.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    hit_ppn   = '0;
    hit_perms = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (rd_valid[w] && (rd_vpn[20*w +: 20] == vpn)) begin
        hit       = 1'b1;
        hit_way   = 2'(w);
        hit_ppn   = rd_ppn[20*w +: 20];
        hit_perms = rd_perms[2*w +: 2];
      end
    end
  end

  // Victim choice: first invalid way, otherwise the smallest LRU count with ties going to the lower way.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    min_way   = '0;
    min_lru   = rd_lru_count[LRU_BITS-1:0];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!rd_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = 2'(w);
      end
    end
    for (int w = 1; w < NUM_WAYS; w++) begin
      if (rd_lru_count[LRU_BITS*w +: LRU_BITS] < min_lru) begin
        min_lru = rd_lru_count[LRU_BITS*w +: LRU_BITS];
        min_way = 2'(w);
      end
    end
    victim_way = inv_found ? inv_way : min_way;
  end

  // Next-state and next-output logic; every output is registered from its _d value.
  always_comb begin
    state_d         = state_q;
    vaddr_d         = vaddr_q;
    is_write_d      = is_write_q;
    walk_ppn_d      = walk_ppn_q;
    walk_perms_d    = walk_perms_q;
    req_ready_d     = req_ready_q;
    resp_valid_d    = resp_valid_q;
    resp_paddr_d    = resp_paddr_q;
    resp_hit_d      = resp_hit_q;
    resp_fault_d    = resp_fault_q;
    wr_en_d         = 1'b0;
    wr_set_index_d  = '0;
    wr_way_d        = '0;
    wr_valid_d      = 1'b0;
    wr_vpn_d        = '0;
    wr_ppn_d        = '0;
    wr_perms_d      = '0;
    wr_lru_count_d  = '0;
    lru_update_en_d = 1'b0;
    lru_set_index_d = '0;
    lru_way_d       = '0;
    ptw_req_valid_d = ptw_req_valid_q;
    ptw_req_vpn_d   = ptw_req_vpn_q;
    hit_count_d     = hit_count_q;
    miss_count_d    = miss_count_q;
    fault_now       = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          vaddr_d     = req_vaddr;
          is_write_d  = req_is_write;
          req_ready_d = 1'b0;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          fault_now       = !perm_ok(hit_perms, is_write_q);
          lru_update_en_d = 1'b1;
          lru_set_index_d = set_idx;
          lru_way_d       = hit_way;
          if (hit_count_q != {CNT_BITS{1'b1}}) hit_count_d = hit_count_q + CNT_ONE;
          resp_hit_d      = 1'b1;
          resp_fault_d    = fault_now;
          resp_paddr_d    = fault_now ? 32'h0 : {hit_ppn, vaddr_q[11:0]};
          state_d         = RESP;
        end else begin
          if (miss_count_q != {CNT_BITS{1'b1}}) miss_count_d = miss_count_q + CNT_ONE;
          ptw_req_valid_d = 1'b1;
          ptw_req_vpn_d   = vpn;
          state_d         = PTW_REQ;
        end
      end
      PTW_REQ: begin
        if (ptw_req_ready) begin
          ptw_req_valid_d = 1'b0;
          ptw_req_vpn_d   = '0;
          state_d         = PTW_WAIT;
        end
      end
      PTW_WAIT: begin
        if (ptw_resp_valid) begin
          if (ptw_resp_fault) begin
            resp_hit_d   = 1'b0;
            resp_fault_d = 1'b1;
            resp_paddr_d = 32'h0;
            state_d      = RESP;
          end else begin
            walk_ppn_d   = ptw_resp_ppn;
            walk_perms_d = ptw_resp_perms;
            state_d      = REFILL;
          end
        end
      end
      REFILL: begin
        fault_now      = !perm_ok(walk_perms_q, is_write_q);
        wr_en_d        = 1'b1;
        wr_set_index_d = set_idx;
        wr_way_d       = victim_way;
        wr_valid_d     = 1'b1;
        wr_vpn_d       = vpn;
        wr_ppn_d       = walk_ppn_q;
        wr_perms_d     = walk_perms_q;
        wr_lru_count_d = '0;
        resp_hit_d     = 1'b0;
        resp_fault_d   = fault_now;
        resp_paddr_d   = fault_now ? 32'h0 : {walk_ppn_q, vaddr_q[11:0]};
        state_d        = RESP;
      end
      RESP: begin
        resp_valid_d = 1'b1;
        if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
          resp_paddr_d = '0;
          resp_hit_d   = 1'b0;
          resp_fault_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      vaddr_q         <= '0;
      is_write_q      <= 1'b0;
      walk_ppn_q      <= '0;
      walk_perms_q    <= '0;
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_paddr_q    <= '0;
      resp_hit_q      <= 1'b0;
      resp_fault_q    <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_set_index_q  <= '0;
      wr_way_q        <= '0;
      wr_valid_q      <= 1'b0;
      wr_vpn_q        <= '0;
      wr_ppn_q        <= '0;
      wr_perms_q      <= '0;
      wr_lru_count_q  <= '0;
      lru_update_en_q <= 1'b0;
      lru_set_index_q <= '0;
      lru_way_q       <= '0;
      ptw_req_valid_q <= 1'b0;
      ptw_req_vpn_q   <= '0;
      hit_count_q     <= '0;
      miss_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      vaddr_q         <= vaddr_d;
      is_write_q      <= is_write_d;
      walk_ppn_q      <= walk_ppn_d;
      walk_perms_q    <= walk_perms_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_paddr_q    <= resp_paddr_d;
      resp_hit_q      <= resp_hit_d;
      resp_fault_q    <= resp_fault_d;
      wr_en_q         <= wr_en_d;
      wr_set_index_q  <= wr_set_index_d;
      wr_way_q        <= wr_way_d;
      wr_valid_q      <= wr_valid_d;
      wr_vpn_q        <= wr_vpn_d;
      wr_ppn_q        <= wr_ppn_d;
      wr_perms_q      <= wr_perms_d;
      wr_lru_count_q  <= wr_lru_count_d;
      lru_update_en_q <= lru_update_en_d;
      lru_set_index_q <= lru_set_index_d;
      lru_way_q       <= lru_way_d;
      ptw_req_valid_q <= ptw_req_valid_d;
      ptw_req_vpn_q   <= ptw_req_vpn_d;
      hit_count_q     <= hit_count_d;
      miss_count_q    <= miss_count_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_paddr    = resp_paddr_q;
  assign resp_hit      = resp_hit_q;
  assign resp_fault    = resp_fault_q;
  assign wr_en         = wr_en_q;
  assign wr_set_index  = wr_set_index_q;
  assign wr_way        = wr_way_q;
  assign wr_valid      = wr_valid_q;
  assign wr_vpn        = wr_vpn_q;
  assign wr_ppn        = wr_ppn_q;
  assign wr_perms      = wr_perms_q;
  assign wr_lru_count  = wr_lru_count_q;
  assign lru_update_en = lru_update_en_q;
  assign lru_set_index = lru_set_index_q;
  assign lru_way       = lru_way_q;
  assign ptw_req_valid = ptw_req_valid_q;
  assign ptw_req_vpn   = ptw_req_vpn_q;
  assign hit_count     = hit_count_q;
  assign miss_count    = miss_count_q;

endmodule

// File: tb/tb_tlb_lookup_ctrl.sv
// Bench for tlb_lookup_ctrl: storage and page-table-walker models around the DUT,
// a set-associative reference TLB that predicts each response, and one compare process.
module tb_tlb_lookup_ctrl;

  logic        clk, rst;
  logic        req_valid, req_ready, req_is_write;
  logic [31:0] req_vaddr;
  logic        resp_valid, resp_ready, resp_hit, resp_fault;
  logic [31:0] resp_paddr;
  logic [3:0]  rd_set_index;
  logic [3:0]  rd_valid;
  logic [79:0] rd_vpn, rd_ppn;
  logic [7:0]  rd_perms;
  logic [15:0] rd_lru_count;
  logic        wr_en, wr_valid;
  logic [3:0]  wr_set_index;
  logic [1:0]  wr_way, wr_perms;
  logic [19:0] wr_vpn, wr_ppn;
  logic [3:0]  wr_lru_count;
  logic        lru_update_en;
  logic [3:0]  lru_set_index;
  logic [1:0]  lru_way;
  logic        ptw_req_valid, ptw_req_ready;
  logic [19:0] ptw_req_vpn;
  logic        ptw_resp_valid, ptw_resp_fault;
  logic [19:0] ptw_resp_ppn;
  logic [1:0]  ptw_resp_perms;
  logic [15:0] hit_count, miss_count;

  tlb_lookup_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr), .req_is_write(req_is_write),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
    .resp_hit(resp_hit), .resp_fault(resp_fault),
    .rd_set_index(rd_set_index), .rd_valid(rd_valid), .rd_vpn(rd_vpn), .rd_ppn(rd_ppn),
    .rd_perms(rd_perms), .rd_lru_count(rd_lru_count),
    .wr_en(wr_en), .wr_set_index(wr_set_index), .wr_way(wr_way), .wr_valid(wr_valid),
    .wr_vpn(wr_vpn), .wr_ppn(wr_ppn), .wr_perms(wr_perms), .wr_lru_count(wr_lru_count),
    .lru_update_en(lru_update_en), .lru_set_index(lru_set_index), .lru_way(lru_way),
    .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready), .ptw_req_vpn(ptw_req_vpn),
    .ptw_resp_valid(ptw_resp_valid), .ptw_resp_ppn(ptw_resp_ppn),
    .ptw_resp_perms(ptw_resp_perms), .ptw_resp_fault(ptw_resp_fault),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- storage model (environment) ----------------
  logic       st_clear;
  logic       st_valid [16][4];
  logic [19:0] st_vpn  [16][4];
  logic [19:0] st_ppn  [16][4];
  logic [1:0]  st_perms[16][4];
  logic [3:0]  st_lru  [16][4];

  always @(posedge clk) begin
    if (st_clear) begin
      for (int s = 0; s < 16; s++)
        for (int w = 0; w < 4; w++) begin
          st_valid[s][w] <= 1'b0; st_vpn[s][w] <= '0; st_ppn[s][w] <= '0;
          st_perms[s][w] <= '0;   st_lru[s][w] <= '0;
        end
    end else begin
      if (wr_en) begin
        st_valid[wr_set_index][wr_way] <= wr_valid;
        st_vpn[wr_set_index][wr_way]   <= wr_vpn;
        st_ppn[wr_set_index][wr_way]   <= wr_ppn;
        st_perms[wr_set_index][wr_way] <= wr_perms;
        st_lru[wr_set_index][wr_way]   <= wr_lru_count;
      end
      if (lru_update_en && st_lru[lru_set_index][lru_way] != 4'hF)
        st_lru[lru_set_index][lru_way] <= st_lru[lru_set_index][lru_way] + 4'd1;
    end
  end

  always_comb begin
    rd_valid = '0; rd_vpn = '0; rd_ppn = '0; rd_perms = '0; rd_lru_count = '0;
    for (int w = 0; w < 4; w++) begin
      rd_valid[w]           = st_valid[rd_set_index][w];
      rd_vpn[20*w +: 20]    = st_vpn[rd_set_index][w];
      rd_ppn[20*w +: 20]    = st_ppn[rd_set_index][w];
      rd_perms[2*w +: 2]    = st_perms[rd_set_index][w];
      rd_lru_count[4*w +: 4] = st_lru[rd_set_index][w];
    end
  end

  // ---------------- page table ----------------
  logic [22:0] pt_ovr [int];  // {fault, perms, ppn}

  task automatic pt_get(input logic [19:0] v, output logic [19:0] p, output logic [1:0] pm, output logic f);
    if (pt_ovr.exists(int'(v))) begin
      {f, pm, p} = pt_ovr[int'(v)];
    end else if (v < 20'h100) begin
      p = v ^ 20'h4C000; pm = 2'b11; f = 1'b0;
    end else begin
      p  = {v[9:0], v[19:10]} ^ 20'h31337;
      pm = (v[5:4] == 2'b00) ? 2'b11 : v[5:4];
      f  = ((v % 20'd11) == 20'd0);
    end
  endtask

  // ---------------- walker model ----------------
  logic        walker_hold;
  int          n_ptw = 0;
  int          wphase = 0;
  int          wdly = 0;
  logic [19:0] wvpn;

  initial begin
    ptw_req_ready = 0; ptw_resp_valid = 0; ptw_resp_ppn = 0; ptw_resp_perms = 0; ptw_resp_fault = 0;
    wvpn = '0;
    forever begin
      @(negedge clk);
      ptw_req_ready = 0; ptw_resp_valid = 0; ptw_resp_ppn = 0; ptw_resp_perms = 0; ptw_resp_fault = 0;
      if (rst) begin
        wphase = 0; wdly = 0;
      end else if (wphase == 0) begin
        if (ptw_req_valid) begin
          if (wdly == 0) begin
            ptw_req_ready = 1; wvpn = ptw_req_vpn; n_ptw++;
            wphase = 1; wdly = $urandom_range(0, 3);
          end else wdly--;
        end
      end else if (!walker_hold) begin
        if (wdly == 0) begin
          pt_get(wvpn, ptw_resp_ppn, ptw_resp_perms, ptw_resp_fault);
          ptw_resp_valid = 1;
          wphase = 0; wdly = $urandom_range(0, 2);
        end else wdly--;
      end
    end
  end

  // ---------------- reference TLB ----------------
  logic        m_valid [16][4];
  logic [19:0] m_vpn   [16][4];
  logic [19:0] m_ppn   [16][4];
  logic [1:0]  m_perms [16][4];
  int          m_lru   [16][4];
  int          m_hits, m_misses;

  logic [31:0] exp_paddr;
  logic        exp_hit, exp_fault;
  logic [3:0]  exp_set;
  logic [1:0]  exp_way, exp_perms;
  logic [19:0] exp_vpn, exp_ppn;
  int          exp_wr, exp_lru;

  task automatic predict(input logic [31:0] va, input logic wr);
    logic [19:0] v, p; logic [1:0] pm; logic f; int s, hw, vic;
    v = va[31:12]; s = int'(v[3:0]); hw = -1;
    for (int w = 0; w < 4; w++) if (hw < 0 && m_valid[s][w] && m_vpn[s][w] == v) hw = w;
    exp_vpn = v; exp_set = v[3:0];
    if (hw >= 0) begin
      f = wr ? !m_perms[s][hw][1] : !m_perms[s][hw][0];
      exp_hit = 1; exp_fault = f; exp_way = 2'(hw);
      exp_paddr = f ? 32'h0 : {m_ppn[s][hw], va[11:0]};
      exp_wr = 0; exp_lru = 1;
      if (m_lru[s][hw] < 15) m_lru[s][hw]++;
      if (m_hits < 65535) m_hits++;
    end else begin
      if (m_misses < 65535) m_misses++;
      pt_get(v, p, pm, f);
      exp_hit = 0; exp_lru = 0;
      if (f) begin
        exp_fault = 1; exp_paddr = 32'h0; exp_wr = 0;
      end else begin
        vic = -1;
        for (int w = 0; w < 4; w++) if (vic < 0 && !m_valid[s][w]) vic = w;
        if (vic < 0) begin
          vic = 0;
          for (int w = 1; w < 4; w++) if (m_lru[s][w] < m_lru[s][vic]) vic = w;
        end
        m_valid[s][vic] = 1; m_vpn[s][vic] = v; m_ppn[s][vic] = p;
        m_perms[s][vic] = pm; m_lru[s][vic] = 0;
        exp_way = 2'(vic); exp_ppn = p; exp_perms = pm; exp_wr = 1;
        exp_fault = wr ? !pm[1] : !pm[0];
        exp_paddr = exp_fault ? 32'h0 : {p, va[11:0]};
      end
    end
  endtask

  // ---------------- compare process ----------------
  logic        chk_en;
  int          wr_seen = 0, lru_seen = 0;
  logic [3:0]  last_wr_set, last_lru_set;
  logic [1:0]  last_wr_way, last_lru_way;
  logic [19:0] last_ptw_vpn;

  always @(negedge clk) begin
    if (chk_en && rst === 1'b0) begin
      chk("wr_lru_excl", 32'(wr_en & lru_update_en), 0);
      if (req_ready) chk("idle_rd_set", rd_set_index, 0);
      if (wr_en) begin
        wr_seen <= wr_seen + 1;
        last_wr_set <= wr_set_index; last_wr_way <= wr_way;
        chk("wr_set", wr_set_index, exp_set);
        chk("wr_way", wr_way, exp_way);
        chk("wr_valid", wr_valid, 1);
        chk("wr_vpn", wr_vpn, exp_vpn);
        chk("wr_ppn", wr_ppn, exp_ppn);
        chk("wr_perms", wr_perms, exp_perms);
        chk("wr_lru", wr_lru_count, 0);
      end
      if (lru_update_en) begin
        lru_seen <= lru_seen + 1;
        last_lru_set <= lru_set_index; last_lru_way <= lru_way;
        chk("lru_set", lru_set_index, exp_set);
        chk("lru_way", lru_way, exp_way);
      end
      if (ptw_req_valid) begin
        last_ptw_vpn <= ptw_req_vpn;
        chk("ptw_vpn", ptw_req_vpn, exp_vpn);
      end
      if (resp_valid) begin
        chk("resp_paddr", resp_paddr, exp_paddr);
        chk("resp_hit", resp_hit, exp_hit);
        chk("resp_fault", resp_fault, exp_fault);
        chk("resp_rd_set", rd_set_index, exp_set);
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
      end
    end
  end

  // ---------------- driver ----------------
  logic [31:0] last_paddr;
  logic        last_hit, last_fault;

  task automatic do_req(input logic [31:0] va, input logic wr);
    int n, k, wb, lb, pb;
    predict(va, wr);
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("req_ready_seen", req_ready, 1);
    wb = wr_seen; lb = lru_seen; pb = n_ptw;
    req_vaddr = va; req_is_write = wr; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    k = 0;
    while (!resp_valid && k < 200) begin @(posedge clk); #1; k++; end
    chk("resp_seen", resp_valid, 1);
    if (exp_hit) chk("hit_latency", k, 2);
    last_paddr = resp_paddr; last_hit = resp_hit; last_fault = resp_fault;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    chk("resp_drop", resp_valid, 0);
    chk("wr_strobes", wr_seen - wb, exp_wr);
    chk("lru_strobes", lru_seen - lb, exp_lru);
    chk("ptw_walks", n_ptw - pb, exp_hit ? 0 : 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int n, wb;
    logic [19:0] rv;
    rst = 1; req_valid = 0; req_vaddr = 0; req_is_write = 0; resp_ready = 0;
    walker_hold = 0; chk_en = 0; st_clear = 1;
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 0; m_vpn[s][w] = 0; m_ppn[s][w] = 0; m_perms[s][w] = 0; m_lru[s][w] = 0;
      end
    m_hits = 0; m_misses = 0;
    pt_ovr[32'h5]  = {1'b0, 2'b11, 20'h12345};
    pt_ovr[32'h77] = {1'b0, 2'b01, 20'h0BEEF};
    pt_ovr[32'h99] = {1'b1, 2'b11, 20'h00000};

    repeat (3) @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_lru_en", lru_update_en, 0);
    chk("rst_ptw_valid", ptw_req_valid, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    st_clear = 0; rst = 0;
    @(posedge clk); #1;
    chk("rel_req_ready", req_ready, 1);
    chk_en = 1;

    // first miss with refill into set 5 way 0
    do_req(32'h00005123, 0);
    chk("t1_ptw_vpn", last_ptw_vpn, 20'h00005);
    chk("t1_wr_set", last_wr_set, 5);
    chk("t1_wr_way", last_wr_way, 0);
    chk("t1_paddr", last_paddr, 32'h12345123);
    chk("t1_hit", last_hit, 0);
    chk("t1_miss_count", miss_count, 1);

    // same page again: hit
    do_req(32'h00005ABC, 0);
    chk("t2_hit", last_hit, 1);
    chk("t2_paddr", last_paddr, 32'h12345ABC);
    chk("t2_lru_set", last_lru_set, 5);
    chk("t2_lru_way", last_lru_way, 0);
    chk("t2_hit_count", hit_count, 1);

    // fill set 3, touch ways 1..3, then evict
    do_req(32'h00003000, 0);
    do_req(32'h00013000, 0);
    do_req(32'h00023000, 0);
    do_req(32'h00033000, 0);
    chk("t3_fill_way", last_wr_way, 3);
    do_req(32'h00013004, 0);
    do_req(32'h00023008, 0);
    do_req(32'h0003300C, 0);
    chk("t3_hit_way", last_lru_way, 3);
    do_req(32'h00043000, 0);
    chk("t3_victim_way", last_wr_way, 0);
    chk("t3_victim_set", last_wr_set, 3);

    // store to a read-only page: faults on refill and on hit
    do_req(32'h00077010, 1);
    chk("t4_refill_fault", last_fault, 1);
    chk("t4_refill_paddr", last_paddr, 0);
    do_req(32'h00077010, 1);
    chk("t4_hit_fault", last_fault, 1);
    chk("t4_hit_hit", last_hit, 1);
    do_req(32'h00077010, 0);
    chk("t4_load_paddr", last_paddr, 32'h0BEEF010);

    // walker fault: no refill, retry misses again
    do_req(32'h00099000, 0);
    chk("t5_fault", last_fault, 1);
    chk("t5_paddr", last_paddr, 0);
    do_req(32'h00099000, 0);
    chk("t5_retry_hit", last_hit, 0);

    // reset while waiting on the walker
    walker_hold = 1; exp_vpn = 20'h0000A; exp_set = 4'hA;
    req_vaddr = 32'h0000A000; req_is_write = 0; req_valid = 1;
    @(posedge clk); #1; req_valid = 0;
    n = 0;
    while (!ptw_req_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("t6_ptw_req", ptw_req_valid, 1);
    n = 0;
    while (ptw_req_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("t6_ptw_acc", ptw_req_valid, 0);
    repeat (2) begin @(posedge clk); #1; end
    wb = wr_seen;
    rst = 1; #1;
    chk("t6_req_ready", req_ready, 0);
    chk("t6_resp_valid", resp_valid, 0);
    chk("t6_wr_en", wr_en, 0);
    chk("t6_ptw_valid", ptw_req_valid, 0);
    chk("t6_rd_set", rd_set_index, 0);
    chk("t6_miss_count", miss_count, 0);
    m_hits = 0; m_misses = 0;
    repeat (2) @(posedge clk); #1;
    rst = 0; walker_hold = 0;
    @(posedge clk); #1;
    chk("t6_rel_ready", req_ready, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("t6_no_write", wr_seen - wb, 0);
    do_req(32'h0000A000, 0);
    chk("t6_retry_hit", last_hit, 0);
    chk("t6_retry_miss_count", miss_count, 1);

    // randomized traffic over a pool larger than the TLB
    for (int i = 0; i < 400; i++) begin
      rv = 20'h100 + 20'($urandom_range(0, 95));
      do_req({rv, 12'($urandom)}, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
